instr_mem_loader: RTL and testbench

- Hardware counterpart to the bench-side instruction image load: the writer that fills the instruction memory the Simulator core fetches from.
- Accepts a byte stream over a valid/ready handshake and frames it as a 16-bit word count followed by big-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory word addresses starting at 0.
- Holds the CPU in reset until loading completes, then releases it.

---
 rtl/instr_mem_loader.sv | 180 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Byte-stream instruction image loader. It takes a 16-bit
//                big-endian word count followed by big-endian 32-bit words.
//                Each word is written to consecutive instruction-memory
//                addresses starting at 0. The CPU is held in reset until the
//                image is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_hold_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [15:0]       word_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0]       C_DEPTH     = 16'(DEPTH);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_idx;
    logic [23:0]         r_buf;        // first three bytes of the word in flight
    logic [ADDR_W-1:0]   r_addr;       // next memory address to write
    logic [15:0]         r_words;      // words consumed, including overflow words
    logic                r_byte_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_data;
    logic                r_cpu_hold;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic [15:0]         r_word_cnt;   // words actually written

    logic                w_accept;
    logic                w_word_done;
    logic                w_last_word;
    logic                w_in_range;
    logic                w_zero_len;
    logic                w_finish;

    // Handshake and framing decode for the current byte
    always_comb begin
        w_accept    = byte_valid_i && r_byte_ready;
        w_word_done = w_accept && (r_state == S_DATA) && (r_byte_idx == 2'd3);
        w_last_word = ((r_words + 16'd1) == r_len);
        w_in_range  = (r_word_cnt < C_DEPTH);
        w_zero_len  = ({r_len[15:8], byte_i} == 16'd0);
        w_finish    = (w_accept && (r_state == S_LEN_LO) && w_zero_len) ||
                      (w_word_done && w_last_word);
    end

    // Session state machine with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_len        <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_buf        <= 24'd0;
            r_addr       <= '0;
            r_words      <= 16'd0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= 32'd0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_word_cnt   <= 16'd0;
        end else begin
            // Write strobe is a single-cycle pulse
            r_mem_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state      <= S_LEN_HI;
                        r_len        <= 16'd0;
                        r_byte_idx   <= 2'd0;
                        r_addr       <= '0;
                        r_words      <= 16'd0;
                        r_word_cnt   <= 16'd0;
                        r_overflow   <= 1'b0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                    end
                end

                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= byte_i;
                        r_state     <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= byte_i;
                        r_state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0:    r_buf[23:16] <= byte_i;
                            2'd1:    r_buf[15:8]  <= byte_i;
                            2'd2:    r_buf[7:0]   <= byte_i;
                            default: begin
                                r_words <= r_words + 16'd1;
                                if (w_in_range) begin
                                    r_mem_we   <= 1'b1;
                                    r_mem_addr <= r_addr;
                                    r_mem_data <= {r_buf, byte_i};
                                    r_word_cnt <= r_word_cnt + 16'd1;
                                    // Saturate so the address never wraps to 0
                                    if (r_addr != C_LAST_ADDR) begin
                                        r_addr <= r_addr + 1'b1;
                                    end
                                end else begin
                                    r_overflow <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                default: r_state <= S_IDLE;
            endcase

            // Completion overrides the per-state next state above
            if (w_finish) begin
                r_state      <= S_DONE;
                r_byte_ready <= 1'b0;
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_cpu_hold   <= 1'b0;
            end
        end
    end

    assign byte_ready_o = r_byte_ready;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign cpu_hold_o   = r_cpu_hold;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign overflow_o   = r_overflow;
    assign word_cnt_o   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Self-checking bench for instr_mem_loader. Expected memory
//                writes and final status come from a queue-based model of
//                the image format.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef logic [7:0] bq_t[$];

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [7:0]        byte_i = 8'd0;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              cpu_hold_o;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;
    logic [15:0]       word_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: image words and the writes they must produce
    logic [31:0] words[$];
    bq_t         stream;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        prev_we = 1'b0;

    instr_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_hold_o   (cpu_hold_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .word_cnt_o   (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every write strobe must match the next expected write, and be one cycle wide
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_we = 1'b0;
        end else begin
            if (mem_we_o) begin
                check("we_pulse", 32'(prev_we), 32'd0);
                check("wr_expected", 32'(exp_addr.size() != 0), 32'd1);
                if (exp_addr.size() != 0) begin
                    check("wr_addr", 32'(mem_addr_o), exp_addr.pop_front());
                    check("wr_data", mem_data_o, exp_data.pop_front());
                end
            end
            prev_we = mem_we_o;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
        check({tag, "_we"},    32'(mem_we_o),     32'd0);
        check({tag, "_addr"},  32'(mem_addr_o),   32'd0);
        check({tag, "_data"},  mem_data_o,        32'd0);
        check({tag, "_hold"},  32'(cpu_hold_o),   32'd1);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        check({tag, "_done"},  32'(done_o),       32'd0);
        check({tag, "_ovf"},   32'(overflow_o),   32'd0);
        check({tag, "_cnt"},   32'(word_cnt_o),   32'd0);
    endtask

    // Image byte stream: 16-bit count, then big-endian words
    task automatic build_stream();
        int n;
        n = words.size();
        stream = {};
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        foreach (words[i]) begin
            stream.push_back(words[i][31:24]);
            stream.push_back(words[i][23:16]);
            stream.push_back(words[i][15:8]);
            stream.push_back(words[i][7:0]);
        end
    endtask

    task automatic expect_writes(input int nwords);
        for (int i = 0; i < nwords && i < DEPTH; i++) begin
            exp_addr.push_back(32'(i));
            exp_data.push_back(words[i]);
        end
    endtask

    // Pulse start at a negedge; returns at the following negedge
    task automatic start_session();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("st_hold",  32'(cpu_hold_o),   32'd1);
        check("st_busy",  32'(busy_o),       32'd1);
        check("st_done",  32'(done_o),       32'd0);
        check("st_ready", 32'(byte_ready_o), 32'd1);
        check("st_cnt",   32'(word_cnt_o),   32'd0);
        check("st_ovf",   32'(overflow_o),   32'd0);
    endtask

    // Mode 0: valid every cycle, 1: valid alternating, 2: random valid + stray start
    task automatic feed(input bq_t q, input int mode);
        int   idx;
        int   cyc;
        int   gaps;
        logic v;
        logic acc;
        idx  = 0;
        cyc  = 0;
        gaps = 0;
        while (idx < q.size() && cyc < 2000) begin
            if (byte_ready_o !== 1'b1) gaps++;
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = (($urandom % 3) != 0);
            endcase
            byte_valid_i = v;
            byte_i       = v ? q[idx] : 8'($urandom);
            start_i      = (mode == 2) && (($urandom % 8) == 0);
            acc          = v && byte_ready_o;
            @(posedge clk_i);
            if (acc) idx++;
            cyc++;
            @(negedge clk_i);
        end
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        byte_i       = 8'd0;
        check("feed_all", 32'(idx), 32'(q.size()));
        check("ready_gap", 32'(gaps), 32'd0);
    endtask

    // Whole session from the current word list; ends checked in DONE
    task automatic run_full(input int mode);
        int n;
        int exp_cnt;
        n       = words.size();
        exp_cnt = (n < DEPTH) ? n : DEPTH;
        build_stream();
        expect_writes(n);
        start_session();
        feed(stream, mode);
        // First negedge after the last byte edge
        check("end_done",  32'(done_o),       32'd1);
        check("end_hold",  32'(cpu_hold_o),   32'd0);
        check("end_busy",  32'(busy_o),       32'd0);
        check("end_ready", 32'(byte_ready_o), 32'd0);
        check("end_cnt",   32'(word_cnt_o),   32'(exp_cnt));
        check("end_ovf",   32'(overflow_o),   32'(n > DEPTH));
        @(negedge clk_i);
        check("pending_wr", 32'(exp_addr.size()), 32'd0);
        // Bytes offered in DONE must be ignored
        for (int i = 0; i < 3; i++) begin
            byte_valid_i = 1'b1;
            byte_i       = 8'($urandom);
            @(negedge clk_i);
        end
        byte_valid_i = 1'b0;
        check("done_cnt",  32'(word_cnt_o), 32'(exp_cnt));
        check("done_hold", 32'(done_o),     32'd1);
    endtask

    initial begin
        bq_t part;

        // Reset state
        repeat (3) @(negedge clk_i);
        check_reset_outputs("rst");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("idle");

        // Two-word image, valid every cycle then alternating
        words = {32'h20080005, 32'h20090003};
        run_full(0);
        run_full(1);

        // Empty image
        words = {};
        run_full(0);

        // Overflow: 34 words of index value
        words = {};
        for (int i = 0; i < 34; i++) words.push_back(32'(i));
        run_full(0);

        // Async reset mid-word: after 2 of 4 bytes of word 1
        words = {32'h11223344, 32'h55667788};
        build_stream();
        expect_writes(1);
        part = {};
        for (int i = 0; i < 8; i++) part.push_back(stream[i]);
        start_session();
        feed(part, 0);
        #2 rst_i = 1'b1;
        #1 check_reset_outputs("arst");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("arst_pending", 32'(exp_addr.size()), 32'd0);
        words = {32'hA5A5_0F0F};
        run_full(0);

        // Reload from DONE
        words = {32'hFFFF_FFFF};
        run_full(0);

        // Randomised images and handshake patterns
        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(0, 40);
            words = {};
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_full($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
